// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit add/subtract processed DIGIT bits per clock, LSB digit first,
// with valid/ready handshakes on both sides. Define DSA_SATURATE_EN to saturate SUM on signed overflow.
module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             SUB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] SUM,
   output logic             Cout,
   output logic             OVF
);

   localparam int            N    = WIDTH / DIGIT;
   localparam int            CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q, cout_q, ovf_q;

   logic [DIGIT-1:0] dig_a, dig_b, dig_s;
   logic             dig_c, c_in_msb, ovf_d;
   logic [WIDTH-1:0] sum_d;

   // Operands shift right each digit so the slice always reads bits [DIGIT-1:0];
   // the result shifts in from the top and is complete after N digits.
   always_comb begin
      // NOTE: sum_d is assigned unconditionally before the optional override, so no latch is inferred.
      dig_a          = a_q[DIGIT-1:0];
      dig_b          = b_q[DIGIT-1:0];
      {dig_c, dig_s} = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry_q};
      c_in_msb       = dig_a[DIGIT-1] ^ dig_b[DIGIT-1] ^ dig_s[DIGIT-1];
      ovf_d          = c_in_msb ^ dig_c;
      sum_d          = WIDTH'({dig_s, sum_q} >> DIGIT);
`ifdef DSA_SATURATE_EN
      // On the last digit dig_a holds the top digit, so its MSB is the sign of A.
      if ((cnt_q == LAST) && ovf_d) begin
         sum_d = dig_a[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= A;
                  b_q     <= B ^ {WIDTH{SUB}};
                  carry_q <= SUB | Cin;
                  sum_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               sum_q   <= sum_d;
               carry_q <= dig_c;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cout_q  <= dig_c;
                  ovf_q   <= ovf_d;
                  cnt_q   <= '0;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign SUM       = sum_q;
   assign Cout      = cout_q;
   assign OVF       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: directed vectors against an arithmetic reference model of digit_serial_adder
// (WIDTH=16, DIGIT=4); honours DSA_SATURATE_EN for the saturated expectations.
module tb_digit_serial_adder;

   localparam int W = 16;
   localparam int D = 4;
   localparam int N = W / D;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] A, B, SUM;
   logic         Cin, SUB, Cout, OVF;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] exp_sum;
   logic         exp_cout, exp_ovf;
   logic         model_valid = 1'b0;

   digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .Cin      (Cin),
      .SUB      (SUB),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .SUM      (SUM),
      .Cout     (Cout),
      .OVF      (OVF)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: whole-word arithmetic, overflow from the sign rule of the operands.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input logic cin, sub);
      logic [W-1:0] bb, s;
      logic [W:0]   full;
      logic         ovf;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
      s    = full[W-1:0];
      ovf  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
`ifdef DSA_SATURATE_EN
      if (ovf) s = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
      return {full[W], ovf, s};
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         check("model armed", 32'(model_valid), 32'd1);
         check("cmp SUM", 32'(SUM), 32'(exp_sum));
         check("cmp Cout", 32'(Cout), 32'(exp_cout));
         check("cmp OVF", 32'(OVF), 32'(exp_ovf));
         check("cmp in_ready", 32'(in_ready), 32'd0);
      end
   end

   task automatic run_op(input logic [W-1:0] a, b, input logic cin, sub,
                         input logic [W-1:0] esum, input logic ecout, eovf, input int hold);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready before issue", 32'(in_ready), 32'd1);
      A = a; B = b; Cin = cin; SUB = sub; in_valid = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk);
      {exp_cout, exp_ovf, exp_sum} = model(a, b, cin, sub);
      model_valid = 1'b1;
      #1 in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         A = W'($urandom); B = W'($urandom); Cin = ~Cin; SUB = ~SUB;
         @(posedge clk); #1; n++;
      end
      check("latency edges", 32'(n), 32'(N));
      check("in_ready in DONE", 32'(in_ready), 32'd0);
      check("literal SUM", 32'(SUM), 32'(esum));
      check("literal Cout", 32'(Cout), 32'(ecout));
      check("literal OVF", 32'(OVF), 32'(eovf));
      for (int i = 0; i < hold; i++) begin
         A = W'($urandom); B = W'($urandom);
         @(posedge clk); #1;
         check("hold out_valid", 32'(out_valid), 32'd1);
         check("hold in_ready", 32'(in_ready), 32'd0);
         check("hold SUM", 32'(SUM), 32'(esum));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      model_valid = 1'b0;
      check("post-handshake out_valid", 32'(out_valid), 32'd0);
      check("post-handshake in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; Cin = 1'b0; SUB = 1'b0;
      #12;
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset SUM", 32'(SUM), 32'd0);
      check("reset Cout", 32'(Cout), 32'd0);
      check("reset OVF", 32'(OVF), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(16'h1234, 16'h0FCC, 1'b1, 1'b0, 16'h2201, 1'b0, 1'b0, 0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
`ifdef DSA_SATURATE_EN
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 0);
`else
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
`endif
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 10);
`ifdef DSA_SATURATE_EN
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 0);
      run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 0);
`else
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
      run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
`endif
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 3);
      run_op(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0);

      // Reset while digit index 2 is in progress; outputs must clear without a clock edge.
      A = 16'h1111; B = 16'h2222; Cin = 1'b0; SUB = 1'b0; in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      check("mid-run in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("async reset in_ready", 32'(in_ready), 32'd1);
      check("async reset out_valid", 32'(out_valid), 32'd0);
      check("async reset SUM", 32'(SUM), 32'd0);
      check("async reset Cout", 32'(Cout), 32'd0);
      check("async reset OVF", 32'(OVF), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
